// File: rtl/axi4l_param_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : axi4l_param_reg_bank
// Purpose  : AXI4-Lite bank of R/W control registers and shadowed RO status words.
// Revision : 1.0 - initial release
// ============================================================================
module axi4l_param_reg_bank #(
    parameter int                         C_S_AXI_DATA_WIDTH = 32,
    parameter int                         C_S_AXI_ADDR_WIDTH = 10,
    parameter int                         NUM_WR_REGS        = 64,
    parameter int                         RD_BASE            = 128,
    parameter int                         NUM_RD_REGS        = 64,
    parameter logic [NUM_WR_REGS*32-1:0]  WR_INIT            = '0,
    parameter int                         SNAP_EN            = 0
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [NUM_WR_REGS*32-1:0]         o_wr_regs,
    output logic [NUM_WR_REGS-1:0]            o_wr_pulse,
    input  logic [NUM_RD_REGS*32-1:0]         i_rd_regs,
    input  logic                              i_snap
);

    localparam int          c_idx_w   = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [31:0] c_nwr     = 32'(NUM_WR_REGS);
    localparam logic [31:0] c_rd_base = 32'(RD_BASE);
    localparam logic [1:0]  c_okay    = 2'b00;
    localparam logic [1:0]  c_slverr  = 2'b10;

    logic                              aw_full_q;
    logic [c_idx_w-1:0]                aw_idx_q;
    logic                              w_full_q;
    logic [31:0]                       wdata_q;
    logic [3:0]                        wstrb_q;
    logic                              bvalid_q;
    logic [1:0]                        bresp_q;
    logic                              rvalid_q;
    logic [31:0]                       rdata_q;
    logic [31:0]                       rdata_d;
    logic [1:0]                        rresp_q;
    logic [1:0]                        rresp_d;
    logic [NUM_RD_REGS-1:0][31:0]      shadow_q;

    logic [NUM_WR_REGS-1:0][31:0]      w_regs;
    logic [NUM_WR_REGS-1:0]            w_pulse;
    logic [NUM_RD_REGS-1:0][31:0]      w_live;
    logic [31:0]                       w_aw_word;
    logic [31:0]                       w_ar_word;
    logic                              w_aw_hs;
    logic                              w_w_hs;
    logic                              w_ar_hs;
    logic                              w_commit;
    logic                              w_wr_legal;
    logic                              w_snap;
    logic                              w_unused;

    assign w_live     = i_rd_regs;
    assign w_aw_hs    = S_AXI_AWVALID & ~aw_full_q;
    assign w_w_hs     = S_AXI_WVALID & ~w_full_q;
    assign w_ar_hs    = S_AXI_ARVALID & ~rvalid_q;
    assign w_commit   = aw_full_q & w_full_q & ~bvalid_q;
    assign w_aw_word  = 32'(aw_idx_q);
    assign w_ar_word  = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
    assign w_wr_legal = (w_aw_word < c_nwr);
    assign w_unused   = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // AW and W are buffered independently; the commit drains both at once.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= c_okay;
        end else begin
            if (w_aw_hs) begin
                aw_full_q <= 1'b1;
                aw_idx_q  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_w_hs) begin
                w_full_q <= 1'b1;
                wdata_q  <= S_AXI_WDATA;
                wstrb_q  <= S_AXI_WSTRB;
            end
            if (w_commit) begin
                aw_full_q <= 1'b0;
                w_full_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= w_wr_legal ? c_okay : c_slverr;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_WR_REGS; k++) begin : g_wr_reg
            logic [31:0] reg_q;
            logic        pulse_q;
            logic        w_hit;

            assign w_hit      = w_commit & w_wr_legal & (w_aw_word == 32'(k));
            assign w_regs[k]  = reg_q;
            assign w_pulse[k] = pulse_q;

            always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
                if (!S_AXI_ARESETN) begin
                    reg_q   <= WR_INIT[32*k +: 32];
                    pulse_q <= 1'b0;
                end else begin
                    pulse_q <= w_hit;
                    for (int b = 0; b < 4; b++) begin
                        if (w_hit && wstrb_q[b]) begin
                            reg_q[8*b +: 8] <= wdata_q[8*b +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

    // A read of RD_BASE doubles as a capture so word 0 and the rest stay coherent.
    assign w_snap = (SNAP_EN == 0) | i_snap | (w_ar_hs & (w_ar_word == c_rd_base));

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            shadow_q <= '0;
        end else if (w_snap) begin
            shadow_q <= w_live;
        end
    end

    always_comb begin
        rdata_d = 32'h0;
        rresp_d = c_slverr;
        for (int k = 0; k < NUM_WR_REGS; k++) begin
            if (w_ar_word == 32'(k)) begin
                rdata_d = w_regs[k];
                rresp_d = c_okay;
            end
        end
        for (int k = 0; k < NUM_RD_REGS; k++) begin
            if (w_ar_word == c_rd_base + 32'(k)) begin
                rdata_d = ((SNAP_EN != 0) && (k == 0)) ? w_live[0] : shadow_q[k];
                rresp_d = c_okay;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= c_okay;
        end else if (w_ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    assign S_AXI_AWREADY = ~aw_full_q;
    assign S_AXI_WREADY  = ~w_full_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = ~rvalid_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign o_wr_regs     = w_regs;
    assign o_wr_pulse    = w_pulse;

endmodule

`default_nettype wire
